// File: rtl/uart_rx_word64_if.sv
// Serial input and 64-bit word output of the 8N1 receiver, plus a state debug tap.
// The receiver is the slave; the bench or upstream logic is the master.
interface uart_rx_word64_if;
   logic        uart_rxd;
   logic [63:0] data_64;
   logic        data_valid;
   logic        frame_err;
   logic        busy;
   logic [2:0]  dbg_state;

   modport master (
      output uart_rxd,
      input  data_64, data_valid, frame_err, busy, dbg_state
   );

   modport slave (
      input  uart_rxd,
      output data_64, data_valid, frame_err, busy, dbg_state
   );
endinterface

// File: rtl/uart_rx_word64.sv
// 8N1 UART receiver that packs eight bytes (first byte in bits [7:0]) into a 64-bit word.
// Partial words are dropped on a framing error, an inter-byte timeout, or reset.
//
// Output handshake: data_valid is a one-cycle strobe with no ready/back-pressure.
// data_64 changes only in a cycle where data_valid is high; the consumer must capture it
// then. frame_err is an independent one-cycle strobe and never coincides with data_valid.
module uart_rx_word64 #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic             clk,
   input  logic             rst,
   uart_rx_word64_if.slave  rx
);
   localparam int HALF     = CLKS_PER_BIT / 2;
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int BW       = $clog2(CLKS_PER_BIT);
   localparam int TW       = $clog2(TO_LIMIT);

   localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BCNT_HALF = BW'(HALF - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TO_LIMIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t      state_q;
   logic        sync1_q;
   logic        rxs_q;
   logic [BW-1:0] bcnt_q;
   logic [2:0]  bit_q;
   logic [2:0]  bidx_q;
   logic [TW-1:0] tcnt_q;
   logic [7:0]  shreg_q;
   logic [63:0] word_q;
   logic [63:0] data_64_q;
   logic        data_valid_q;
   logic        frame_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sync1_q      <= 1'b1;
         rxs_q        <= 1'b1;
         bcnt_q       <= '0;
         bit_q        <= 3'd0;
         bidx_q       <= 3'd0;
         tcnt_q       <= '0;
         shreg_q      <= 8'd0;
         word_q       <= 64'd0;
         data_64_q    <= 64'd0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync1_q      <= rx.uart_rxd;
         rxs_q        <= sync1_q;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bidx_q != 3'd0) begin
                  if (tcnt_q == TCNT_LAST) begin
                     bidx_q <= 3'd0;
                     tcnt_q <= '0;
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
               // A timeout in this same cycle has already dropped the word above.
               if (!rxs_q) begin
                  state_q <= START;
                  bcnt_q  <= '0;
                  tcnt_q  <= '0;
               end
            end
            START: begin
               if (bcnt_q == BCNT_HALF) begin
                  bcnt_q  <= '0;
                  bit_q   <= 3'd0;
                  state_q <= rxs_q ? IDLE : DATA;
               end else begin
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
            DATA: begin
               if (bcnt_q == BCNT_LAST) begin
                  bcnt_q  <= '0;
                  shreg_q <= {rxs_q, shreg_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end else begin
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
            STOP: begin
               if (bcnt_q == BCNT_LAST) begin
                  bcnt_q <= '0;
                  if (rxs_q) begin
                     word_q[{bidx_q, 3'b000} +: 8] <= shreg_q;
                     if (bidx_q == 3'd7) begin
                        data_64_q    <= {shreg_q, word_q[55:0]};
                        data_valid_q <= 1'b1;
                     end
                     bidx_q  <= bidx_q + 1'b1;
                     state_q <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     bidx_q      <= 3'd0;
                     state_q     <= BREAK;
                  end
               end else begin
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
            BREAK: begin
               if (rxs_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx.data_64    = data_64_q;
   assign rx.data_valid = data_valid_q;
   assign rx.frame_err  = frame_err_q;
   assign rx.busy       = (state_q != IDLE) || (bidx_q != 3'd0);
   assign rx.dbg_state  = state_q;
endmodule
